// File: rtl/mtr_drv_if.sv
// mtr_drv_if: command/drive bundle between the balance controller and the
// motor driver.
//   lft_spd, rght_spd : signed 12-bit wheel speed commands (two's complement)
//   en                : drive enable; low forces all drives off
//   *_fwd_pwm/*_rev_pwm : per-motor H-bridge PWM drives
//   prd_strt          : one-clock pulse in the first cycle of each PWM period
// master drives the commands; slave (the driver) produces the PWM outputs.
interface mtr_drv_if;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        en;
  logic        lft_fwd_pwm;
  logic        lft_rev_pwm;
  logic        rght_fwd_pwm;
  logic        rght_rev_pwm;
  logic        prd_strt;

  modport master (
    output lft_spd, rght_spd, en,
    input  lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, prd_strt
  );

  modport slave (
    input  lft_spd, rght_spd, en,
    output lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, prd_strt
  );
endinterface

// File: rtl/mtr_drv.sv
// mtr_drv: converts signed left/right wheel speed commands into per-motor
// forward/reverse PWM drives for the H-bridges.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : mtr_drv_if.slave -- speed commands and enable in, four PWM
//           drives and the period-start pulse out (all outputs registered)
// Duty and direction are latched only at the period boundary (cnt wrapping
// from all-ones to zero), a deadband offset is added to any non-zero
// magnitude, and a direction reversal between two non-zero duties blanks the
// motor for one whole period.
module mtr_drv #(
  parameter int          PWM_BITS = 11,
  parameter int unsigned MIN_DUTY = 32'h0A0
) (
  input  logic      clk,
  input  logic      rst_n,
  mtr_drv_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [12:0]         MIN_EXT  = 13'(MIN_DUTY);
  localparam logic [12:0]         MAX_EXT  = 13'(DUTY_MAX);

  typedef struct packed {
    logic [PWM_BITS-1:0] duty;
    logic                dir;    // 1 = reverse
    logic                blank;  // set for the period following a reversal
  } mtr_t;

  // Saturating |spd| + deadband offset; zero command stays exactly zero.
  function automatic logic [PWM_BITS-1:0] duty_of(input logic [11:0] spd);
    logic [11:0] mag;
    logic [12:0] sum;
    mag = spd[11] ? 12'(~spd + 12'd1) : spd;
    if (mag == 12'h800) mag = 12'h7FF;  // -2048 has no positive twin
    sum = {1'b0, mag} + MIN_EXT;
    if (spd == '0)          duty_of = '0;
    else if (sum > MAX_EXT) duty_of = DUTY_MAX;
    else                    duty_of = sum[PWM_BITS-1:0];
  endfunction

  logic [PWM_BITS-1:0] cnt;
  logic                prd;
  mtr_t                mtr      [2];
  logic                fwd      [2];
  logic                rev      [2];
  logic [11:0]         spd      [2];
  logic [PWM_BITS-1:0] nxt_duty [2];
  logic                nxt_dir  [2];
  logic                raw      [2];
  logic                bndry;

  assign spd[0] = bus.lft_spd;
  assign spd[1] = bus.rght_spd;
  assign bndry  = (cnt == DUTY_MAX);

  always_comb begin
    for (int m = 0; m < 2; m++) begin
      nxt_duty[m] = duty_of(spd[m]);
      nxt_dir[m]  = spd[m][11];
      raw[m]      = (cnt < mtr[m].duty) & ~mtr[m].blank;
    end
  end

  // NOTE: all state, including the per-motor array, uses non-blocking
  // assignments and is cleared by reset so every element starts defined.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      prd <= 1'b0;
      for (int m = 0; m < 2; m++) begin
        mtr[m] <= '0;
        fwd[m] <= 1'b0;
        rev[m] <= 1'b0;
      end
    end else begin
      cnt <= cnt + 1'b1;
      prd <= bndry;
      for (int m = 0; m < 2; m++) begin
        // Gating with en here makes the drives drop on the very next clock.
        fwd[m] <= bus.en & raw[m] & ~mtr[m].dir;
        rev[m] <= bus.en & raw[m] &  mtr[m].dir;
        if (!bus.en) begin
          // Disable wins over a coincident boundary.
          mtr[m].duty  <= '0;
          mtr[m].blank <= 1'b0;
        end else if (bndry) begin
          if ((nxt_duty[m] != '0) && (mtr[m].duty != '0) &&
              (nxt_dir[m] != mtr[m].dir)) begin
            // Reversal between live duties: idle one period; the magnitude is
            // re-evaluated from the live input at the following boundary.
            mtr[m].duty  <= '0;
            mtr[m].blank <= 1'b1;
          end else begin
            mtr[m].duty  <= nxt_duty[m];
            mtr[m].blank <= 1'b0;
          end
          mtr[m].dir <= nxt_dir[m];
        end
      end
    end
  end

  assign bus.lft_fwd_pwm  = fwd[0];
  assign bus.lft_rev_pwm  = rev[0];
  assign bus.rght_fwd_pwm = fwd[1];
  assign bus.rght_rev_pwm = rev[1];
  assign bus.prd_strt     = prd;

endmodule

// File: tb/tb_mtr_drv.sv
// tb_mtr_drv: directed bench for mtr_drv. Per-period expected high-cycle
// counts for the four drives are queued when the speeds are driven and
// compared when the window for that period closes; the run of high cycles
// must also start at cnt = 1 and be contiguous.
module tb_mtr_drv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mtr_drv_if bus_if();

  mtr_drv #(.PWM_BITS(11), .MIN_DUTY(32'h0A0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  typedef struct packed {
    logic [31:0]      win;
    logic [3:0][11:0] n;   // 0 lf, 1 lr, 2 rf, 3 rr
  } exp_t;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [10:0] tb_cnt = '0;
  logic        tb_prd = 1'b0;
  logic        mon_on = 1'b0;
  int          win_idx = 0;
  int          hi    [4] = '{0, 0, 0, 0};
  int          first [4] = '{0, 0, 0, 0};
  int          last  [4] = '{0, 0, 0, 0};
  logic [3:0]  o_now;
  string       nm    [4] = '{"lf", "lr", "rf", "rr"};

  assign o_now = {bus_if.rght_rev_pwm, bus_if.rght_fwd_pwm,
                  bus_if.lft_rev_pwm, bus_if.lft_fwd_pwm};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference period counter and period-start pulse.
  always @(posedge clk) begin
    tb_cnt <= rst_n ? tb_cnt + 11'd1 : 11'd0;
    tb_prd <= rst_n && (tb_cnt == 11'd2047);
  end

  task automatic close_window();
    exp_t e;
    if (sb.size() > 0 && sb[0].win == win_idx) begin
      e = sb.pop_front();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("win%0d_%s_cnt", win_idx, nm[k]), hi[k], 32'(e.n[k]));
        if (hi[k] > 0) begin
          check($sformatf("win%0d_%s_start", win_idx, nm[k]), first[k], 1);
          check($sformatf("win%0d_%s_contig", win_idx, nm[k]), last[k] - first[k] + 1, hi[k]);
        end
      end
    end
    win_idx++;
    for (int k = 0; k < 4; k++) hi[k] = 0;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("prd_strt", bus_if.prd_strt, tb_prd);
      check("fwd_rev_overlap", (o_now[0] & o_now[1]) | (o_now[2] & o_now[3]), 0);
      if (tb_cnt == 11'd0) close_window();
      for (int k = 0; k < 4; k++) begin
        if (o_now[k]) begin
          if (hi[k] == 0) first[k] = int'(tb_cnt);
          last[k] = int'(tb_cnt);
          hi[k]++;
        end
      end
    end
  end

  task automatic wait_cnt(input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_cnt != 11'(v) && n < 5000);
    if (tb_cnt != 11'(v)) check("wait_cnt_timeout", tb_cnt, v);
  endtask

  task automatic push(input int w, input int lf, input int lr, input int rf, input int rr);
    exp_t e;
    e.win  = 32'(w);
    e.n[0] = 12'(lf);
    e.n[1] = 12'(lr);
    e.n[2] = 12'(rf);
    e.n[3] = 12'(rr);
    sb.push_back(e);
  endtask

  // Drive new speeds mid-period; they govern the following period.
  task automatic step(input int lft, input int rght,
                      input int lf, input int lr, input int rf, input int rr);
    wait_cnt(1000);
    bus_if.lft_spd  = 12'(lft);
    bus_if.rght_spd = 12'(rght);
    push(win_idx + 1, lf, lr, rf, rr);
  endtask

  initial begin
    int n;
    bus_if.lft_spd  = '0;
    bus_if.rght_spd = '0;
    bus_if.en       = 1'b0;

    // Reset held for three clocks.
    @(posedge clk);
    @(negedge clk);
    mon_on = 1'b1;
    check("rst_outputs", {o_now, bus_if.prd_strt}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    bus_if.en = 1'b1;

    // Zero commands: nothing drives.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Forward with deadband offset: 400 + 160.
    step(400, 0, 560, 0, 0, 0);
    // Right at -2048 saturates to 2047 in reverse.
    step(400, -2048, 560, 0, 0, 2047);
    // Right reverses to +2047: one blanked period, then forward saturated.
    step(400, 2047, 560, 0, 0, 0);
    step(400, 2047, 560, 0, 2047, 0);
    // Left +300 -> -300: one blanked period, then 460 in reverse.
    step(300, 2047, 460, 0, 2047, 0);
    step(-300, 2047, 0, 0, 2047, 0);
    step(-300, 2047, 0, 460, 2047, 0);
    // Through zero needs no blanking.
    step(0, 0, 0, 0, 0, 0);
    // 1000 + 160 = 1160, but en drops at cnt 500 of that period.
    step(1000, 0, 500, 0, 0, 0);
    wait_cnt(500);
    check("en_drop_before", bus_if.lft_fwd_pwm, 1);
    bus_if.en = 1'b0;
    @(negedge clk);
    check("en_drop_after", o_now, 0);
    wait_cnt(1200);
    bus_if.en = 1'b1;
    push(win_idx + 1, 1160, 0, 0, 0);

    // en low exactly on the boundary edge: the next period stays dark.
    wait_cnt(2047);
    wait_cnt(2047);
    push(win_idx + 1, 0, 0, 0, 0);
    bus_if.en = 1'b0;
    wait_cnt(1000);
    bus_if.en = 1'b1;
    // Next period is cut short by a reset at cnt 900.
    push(win_idx + 1, 900, 0, 0, 0);

    wait_cnt(900);
    check("rst_mid_before", bus_if.lft_fwd_pwm, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_after", o_now, 0);
    rst_n = 1'b1;
    wait_cnt(1000);
    push(win_idx, 0, 0, 0, 0);
    push(win_idx + 1, 1160, 0, 0, 0);

    n = 0;
    while (sb.size() > 0 && n < 3 * 2048) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
